ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 26 ++
 rtl/ex_muldiv.sv | 136 +++++++++++++
 tb/tb_ex_muldiv.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: RV32M funct3 encodings,
// FSM states and operand-class helpers.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*XLEN+1 accumulator: shift-add for multiply
// ({carry, hi, multiplier}) or restoring subtract for divide ({rem, quotient}).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN:0]   acc_out
);
    logic [XLEN:0]   sum;
    logic [2*XLEN:0] sh;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, (acc_in[0] ? opnd : '0)};
        sh   = acc_in << 1;
        diff = {1'b0, sh[2*XLEN:XLEN]} - {2'b0, opnd};
        if (is_div)
            // a borrow means the trial subtract failed: keep the shifted remainder
            acc_out = diff[XLEN+1] ? sh : {diff[XLEN:0], sh[XLEN-1:1], 1'b1};
        else
            acc_out = {1'b0, sum, acc_in[XLEN-1:1]};
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: XLEN+2 cycle latency.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero / signed overflow in 1 cycle.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    state_e            state, state_nx;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, opnd_q;
    logic [2*XLEN:0]   acc, acc_nx;
    logic [CW-1:0]     cnt;
    logic              a_neg_q, b_neg_q, dz_q, ovf_q;

    logic              a_neg, b_neg, dz_in, ovf_in, early;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    function automatic logic [XLEN-1:0] special_res(input logic is_rem,
                                                    input logic [XLEN-1:0] a,
                                                    input logic dz);
        if (dz) return is_rem ? a : '1;
        return is_rem ? '0 : a;
    endfunction

    always_comb begin
        a_neg  = signed_a(op) && src1[XLEN-1];
        b_neg  = signed_b(op) && src2[XLEN-1];
        a_mag  = a_neg ? -src1 : src1;
        b_mag  = b_neg ? -src2 : src2;
        dz_in  = is_div(op) && (src2 == '0);
        ovf_in = ((op == OP_DIV) || (op == OP_REM)) &&
                 (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early = dz_in || ovf_in;
`else
    assign early = 1'b0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .acc_in  (acc),
        .opnd    (opnd_q),
        .acc_out (acc_nx)
    );

    // Iterations run on magnitudes; signs are reapplied here
    always_comb begin
        prod = acc[2*XLEN-1:0];
        quo  = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        if (a_neg_q ^ b_neg_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (a_neg_q) rem = -rem;
        if (!op_q[2])
            fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (dz_q || ovf_q)
            fix_res = special_res(op_q[1], a_q, dz_q);
        else
            fix_res = op_q[1] ? rem : quo;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (valid_in) state_nx = early ? DONE : CALC;
                CALC:    if (cnt == CW'(XLEN-1)) state_nx = FIX;
                FIX:     state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            opnd_q  <= '0;
            acc     <= '0;
            cnt     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && valid_in && !flush) begin
                op_q    <= op;
                a_q     <= src1;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                dz_q    <= dz_in;
                ovf_q   <= ovf_in;
                cnt     <= '0;
                acc     <= {{(XLEN+1){1'b0}}, (op[2] ? a_mag : b_mag)};
                opnd_q  <= op[2] ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
                if (early) result <= special_res(op[1], src1, dz_in);
`endif
            end
            if (state == CALC) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX && !flush) result <= fix_res;
        end
    end

    assign valid_out = (state == DONE) && !flush;
    assign stall     = (state == IDLE && valid_in) || (state == CALC) || (state == FIX);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (XLEN=32): directed corner vectors plus random ops
// checked against a 64-bit arithmetic reference model.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic        flush;
    logic        stall, valid_out;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    ex_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .stall     (stall),
        .valid_out (valid_out),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, RISC-V special cases
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        case (o)
            OP_MUL:    begin p = 64'(sa * sb);           return p[31:0];  end
            OP_MULH:   begin p = 64'(sa * sb);           return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;                return p[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(sa / sb); return p[31:0];
            end
            OP_DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            OP_REM:    begin
                if (b == 0) return a;
                p = 64'(sa % sb); return p[31:0];
            end
            default:   begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`endif
        return 34;
    endfunction

    // Monitor: every valid_out must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: valid_out=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat, n_st;
        bit seen;
        lat = exp_lat(o, a, b);
        @(posedge clk); #1;
        valid_in = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk);
        check("accept_stall", {31'd0, stall}, 32'd1);
        sb_q.push_back('{exp, cyc, lat});
        @(posedge clk); #1;
        valid_in = 1'b0; src1 = $urandom; src2 = $urandom; op = 3'($urandom);
        n_st = 1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (valid_out) begin
                seen = 1'b1;
                check("done_stall", {31'd0, stall}, 32'd0);
            end else if (stall) begin
                n_st++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no valid_out within 100 cycles for op %0d", o);
            sb_q.delete();
        end
        check("stall_cycles", 32'(n_st), 32'(lat));
        @(negedge clk);
        check("hold_result", result, exp);
        check("valid_pulse", {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        rst = 1'b1; valid_in = 1'b0; op = '0; src1 = '0; src2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_result", result, 32'd0);

        // Directed corner vectors
        run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op(OP_DIVU,   32'd100,        32'd7,         32'd14);
        run_op(OP_REMU,   32'd100,        32'd7,         32'd2);
        run_op(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op(OP_REM,    32'd5,          32'd0,         32'd5);
        run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        run_op(OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF);

        // Flush mid-calculation, then a fresh MUL right after
        @(posedge clk); #1;
        valid_in = 1'b1; op = OP_MUL; src1 = 32'd5; src2 = 32'd6;
        @(posedge clk); #1 valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_valid", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("post_flush_stall", {31'd0, stall}, 32'd0);
        check("post_flush_valid", {31'd0, valid_out}, 32'd0);
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12);

        // Flush landing on the DONE cycle must mask valid_out
        @(posedge clk); #1;
        valid_in = 1'b1; op = OP_MUL; src1 = 32'd2; src2 = 32'd2;
        @(posedge clk); #1 valid_in = 1'b0;
        repeat (33) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("done_flush_valid", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("done_flush_stall", {31'd0, stall}, 32'd0);

        // Randomized ops with injected corner operands
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(o, a, b, model(o, a, b));
        end

        // Reset 20 cycles into a DIV, with valid_in held during reset
        @(posedge clk); #1;
        valid_in = 1'b1; op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk); #1 valid_in = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1; valid_in = 1'b1; op = OP_MUL; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk); #1 rst = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        check("rst_no_accept", {31'd0, stall}, 32'd0);
        repeat (40) @(negedge clk);
        check("rst_quiet_result", result, 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
